array_heap: RTL
===============

Name: array_heap

Overview:
- Parametrised successor to the single-array word store. Holds many Java-style arrays in one block RAM heap.
- Supports four operations: allocation (newarray), element load (iaload), element store (iastore) and arraylength.
- Performs null, bounds, negative-size and out-of-memory checks, and signals them to the control unit through a start/done handshake.
- Heap layout: an array reference r points at a header word holding the length; elements occupy words r+1 .. r+len. Reference 0 is null; heap word 0 is never allocated.

Parameters:
DATA, 32, element and readvalue width in bits (at least 32, so a length fits).
HEAP_SIZE, 1024, heap depth in words.
ADDR, $clog2(HEAP_SIZE), localparam, width of references and heap addresses.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  operation request, sampled only in IDLE
op  in  2  00 LOAD, 01 STORE, 10 NEWARRAY, 11 LENGTH
aref  in  ADDR  array reference (LOAD/STORE/LENGTH)
index  in  32  element index, signed (LOAD/STORE)
count  in  32  element count, signed (NEWARRAY)
writevalue  in  DATA  store data (STORE)
readvalue  out  DATA  LOAD element, LENGTH result, or NEWARRAY reference (zero-extended)
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
err  out  3  error code, valid with done: 0 none, 1 null ref, 2 index out of bounds, 3 negative size, 4 out of memory
free_words  out  ADDR+1  HEAP_SIZE - alloc_ptr

Behaviour:
- Memory: internal single-port RAM. Read is registered; data is valid one cycle after the address register is clocked. A write commits on the edge after write-enable and address are registered.
- Reset values: state IDLE, alloc_ptr=1, readvalue=0, busy=0, done=0, err=0, write-enable=0, free_words=HEAP_SIZE-1.
- Reset mid-operation aborts immediately; any pending write is suppressed. RAM contents are not cleared, but all arrays become logically freed.
- Edge numbering: E0 is the edge where IDLE samples start=1. All inputs are latched at E0. busy=1 from after E0 until the cycle done is high, inclusive.
- States: IDLE, ALLOC, HDR_WAIT, HDR_CHK, ELEM_WAIT, FIN.
- NEWARRAY at E0:
  - count<0: go to FIN, err=3.
  - alloc_ptr+count+1 > HEAP_SIZE (computed in 33+ bits): go to FIN, err=4.
  - Otherwise: address=alloc_ptr, write header word = count, go to ALLOC.
  - E1 (ALLOC): readvalue=old alloc_ptr, alloc_ptr += count+1, done. Latency 1.
  - count=0 is legal and consumes one header word.
- LOAD/STORE/LENGTH at E0:
  - aref==0: FIN, err=1, done at E1, no RAM access.
  - Otherwise: address=aref, go to HDR_WAIT.
  - E1: go to HDR_CHK.
  - E2 (header valid):
    - LENGTH: readvalue=header, done. Latency 2.
    - LOAD/STORE with index<0 or index>=length (signed compare): err=2, done at E2. No write occurs; readvalue unchanged.
    - LOAD: address=aref+1+index (ADDR bits), go to ELEM_WAIT. E3 go to FIN; E4 readvalue=RAM data, done. Latency 4.
    - STORE: address=aref+1+index, write writevalue, go to FIN; write commits and done at E3. Latency 3.
- Error latencies: errors detected at E0 give done at E1; err=2 gives done at E2.
- done, err:
  - done is high exactly one cycle.
  - err is nonzero only while done=1.
  - The state returns to IDLE on the done cycle; a new start is accepted on the following edge.
- Simultaneous and illegal events:
  - start while busy is ignored; no queueing.
  - A stale or dangling reference is not detected; behaviour is defined only for references returned by NEWARRAY since reset.
- readvalue holds its value until the next successful LOAD, LENGTH or NEWARRAY.
- free_words is updated combinationally from alloc_ptr.

Test Plan:
1. After reset: NEWARRAY count=3 -> done at E1, readvalue=1, err=0, free_words=HEAP_SIZE-5. NEWARRAY count=2 -> readvalue=5.
2. STORE ref=1 idx=2 val=0xDEADBEEF (done at E3), then LOAD ref=1 idx=2 -> done at E4, readvalue=0xDEADBEEF. LENGTH ref=5 -> readvalue=2, done at E2.
3. LOAD ref=1 idx=3 -> err=2 at E2. STORE idx=-1 -> err=2, and a following LOAD of idx 0..2 shows no corruption. LOAD ref=0 -> err=1 at E1.
4. NEWARRAY count=-4 -> err=3. NEWARRAY count=HEAP_SIZE-1 on a fresh heap -> err=4 (needs HEAP_SIZE words). Then count=HEAP_SIZE-2 -> success, free_words=0, and any further NEWARRAY count=0 -> err=4.
5. Pulse start every cycle during a LOAD -> only one done, no extra operations. Assert rst at E2 of a STORE -> target word unchanged (check via NEWARRAY-free readback after reset); busy=0, alloc_ptr=1.

Source files
------------

// File: rtl/array_heap.sv
// rtl/array_heap.sv - block-RAM heap of length-prefixed arrays with newarray/iaload/iastore/arraylength
module array_heap #(
    parameter int DATA      = 32,
    parameter int HEAP_SIZE = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [$clog2(HEAP_SIZE)-1:0] aref,
    input  logic [31:0]       index,
    input  logic [31:0]       count,
    input  logic [DATA-1:0]   writevalue,
    output logic [DATA-1:0]   readvalue,
    output logic              busy,
    output logic              done,
    output logic [2:0]        err,
    output logic [$clog2(HEAP_SIZE):0] free_words
);
    localparam int ADDR = $clog2(HEAP_SIZE);

    localparam logic [1:0] OP_LOAD     = 2'b00;
    localparam logic [1:0] OP_STORE    = 2'b01;
    localparam logic [1:0] OP_NEWARRAY = 2'b10;
    localparam logic [1:0] OP_LENGTH   = 2'b11;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_NULL   = 3'd1;
    localparam logic [2:0] ERR_BOUNDS = 3'd2;
    localparam logic [2:0] ERR_NEG    = 3'd3;
    localparam logic [2:0] ERR_OOM    = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALLOC,
        S_HDR_WAIT,
        S_HDR_CHK,
        S_ELEM_WAIT,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR-1:0]   aref_q, aref_d;
    logic [31:0]       index_q, index_d;
    logic [ADDR:0]     count_q, count_d;
    logic [DATA-1:0]   wval_q, wval_d;
    logic [ADDR:0]     alloc_ptr_q, alloc_ptr_d;
    logic [DATA-1:0]   readvalue_q, readvalue_d;
    logic              done_q, done_d;
    logic [2:0]        err_q, err_d;
    logic [2:0]        err_pend_q, err_pend_d;
    logic [ADDR-1:0]   addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA-1:0]   wdata_q, wdata_d;
    logic [DATA-1:0]   rdata_q;
    logic [DATA-1:0]   mem [HEAP_SIZE];

    // Allocation need evaluated wide enough that a huge count cannot wrap.
    logic [33:0]       need;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        aref_d      = aref_q;
        index_d     = index_q;
        count_d     = count_q;
        wval_d      = wval_q;
        alloc_ptr_d = alloc_ptr_q;
        readvalue_d = readvalue_q;
        done_d      = 1'b0;
        err_d       = ERR_NONE;
        err_pend_d  = err_pend_q;
        addr_d      = addr_q;
        we_d        = 1'b0;
        wdata_d     = wdata_q;
        need        = 34'(alloc_ptr_q) + {2'b00, count} + 34'd1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d       = op;
                    aref_d     = aref;
                    index_d    = index;
                    count_d    = count[ADDR:0];
                    wval_d     = writevalue;
                    err_pend_d = ERR_NONE;
                    if (op == OP_NEWARRAY) begin
                        if (count[31]) begin
                            err_pend_d = ERR_NEG;
                            state_d    = S_FIN;
                        end else if (need > 34'(HEAP_SIZE)) begin
                            err_pend_d = ERR_OOM;
                            state_d    = S_FIN;
                        end else begin
                            addr_d  = alloc_ptr_q[ADDR-1:0];
                            we_d    = 1'b1;
                            wdata_d = DATA'(count);
                            state_d = S_ALLOC;
                        end
                    end else if (aref == '0) begin
                        err_pend_d = ERR_NULL;
                        state_d    = S_FIN;
                    end else begin
                        addr_d  = aref;
                        state_d = S_HDR_WAIT;
                    end
                end
            end
            S_ALLOC: begin
                readvalue_d = DATA'(alloc_ptr_q);
                alloc_ptr_d = alloc_ptr_q + count_q + (ADDR+1)'(1);
                done_d      = 1'b1;
                state_d     = S_IDLE;
            end
            S_HDR_WAIT: begin
                state_d = S_HDR_CHK;
            end
            S_HDR_CHK: begin
                if (op_q == OP_LENGTH) begin
                    readvalue_d = rdata_q;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                end else if (index_q[31] || ($signed(index_q) >= $signed(rdata_q[31:0]))) begin
                    err_d   = ERR_BOUNDS;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    addr_d = aref_q + ADDR'(1) + index_q[ADDR-1:0];
                    if (op_q == OP_LOAD) begin
                        state_d = S_ELEM_WAIT;
                    end else begin
                        we_d    = 1'b1;
                        wdata_d = wval_q;
                        state_d = S_FIN;
                    end
                end
            end
            S_ELEM_WAIT: begin
                state_d = S_FIN;
            end
            S_FIN: begin
                done_d  = 1'b1;
                err_d   = err_pend_q;
                if ((err_pend_q == ERR_NONE) && (op_q == OP_LOAD)) begin
                    readvalue_d = rdata_q;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_LOAD;
            aref_q      <= '0;
            index_q     <= '0;
            count_q     <= '0;
            wval_q      <= '0;
            alloc_ptr_q <= (ADDR+1)'(1);
            readvalue_q <= '0;
            done_q      <= 1'b0;
            err_q       <= ERR_NONE;
            err_pend_q  <= ERR_NONE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            aref_q      <= aref_d;
            index_q     <= index_d;
            count_q     <= count_d;
            wval_q      <= wval_d;
            alloc_ptr_q <= alloc_ptr_d;
            readvalue_q <= readvalue_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_pend_q  <= err_pend_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
        end
    end

    // Reset on the commit edge squashes a write that was already registered.
    always_ff @(posedge clk) begin
        if (we_q && !rst) begin
            mem[addr_q] <= wdata_q;
        end
        rdata_q <= mem[addr_q];
    end

    assign readvalue  = readvalue_q;
    assign done       = done_q;
    assign err        = err_q;
    assign busy       = (state_q != S_IDLE) || done_q;
    assign free_words = (ADDR+1)'(HEAP_SIZE) - alloc_ptr_q;

endmodule
